// File: rtl/tcam_update_ctrl.sv
// Write-side master for the TCAM write port: accepts update commands, waits out BUSY and issues one WE
// strobe per entry. Define TCAM_UPDATE_CLEAR_EN to build the clear-all sweep (op 10).
module tcam_update_ctrl #(
  parameter int unsigned                  C_TCAM_ADDR_WIDTH = 5,
  parameter int unsigned                  C_TCAM_DATA_WIDTH = 32,
  parameter logic [C_TCAM_DATA_WIDTH-1:0] C_INVALID_KEY     = '1,
  parameter int unsigned                  C_BUSY_TIMEOUT    = 255
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         s_cmd_valid,
  output logic                         s_cmd_ready,
  input  logic [1:0]                   s_cmd_op,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [C_TCAM_DATA_WIDTH-1:0] s_cmd_key,
  input  logic [C_TCAM_DATA_WIDTH-1:0] s_cmd_mask,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code,
  output logic [31:0]                  wr_count,
  output logic                         TCAM_WE,
  output logic [C_TCAM_ADDR_WIDTH-1:0] TCAM_ADDR_WR,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_DIN,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_DATA_MASK,
  input  logic                         TCAM_BUSY
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FREE = 2'd1,
    S_ISSUE     = 2'd2,
    S_WAIT_ACK  = 2'd3
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_INVAL = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_OP  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_e                         state_q;
  logic                           we_q;
  logic [C_TCAM_ADDR_WIDTH-1:0]   addr_q;
  logic [C_TCAM_DATA_WIDTH-1:0]   din_q;
  logic [C_TCAM_DATA_WIDTH-1:0]   mask_q;
  logic                           done_q;
  logic                           error_q;
  logic [1:0]                     err_code_q;
  logic [31:0]                    wr_count_q;
  logic [7:0]                     busy_cnt_q;
  logic [8:0]                     busy_cnt_d;
  logic                           timeout_hit;
  logic                           op_legal;
`ifdef TCAM_UPDATE_CLEAR_EN
  logic                           clear_q;
`endif

  // The wait counter trips on the BUSY cycle that brings the run up to C_BUSY_TIMEOUT.
  assign busy_cnt_d  = {1'b0, busy_cnt_q} + 9'd1;
  assign timeout_hit = (32'(busy_cnt_d) >= C_BUSY_TIMEOUT);

`ifdef TCAM_UPDATE_CLEAR_EN
  assign op_legal = (s_cmd_op != OP_RSVD);
`else
  assign op_legal = (s_cmd_op == OP_WRITE) || (s_cmd_op == OP_INVAL);
`endif

  // NOTE: ready is gated by RST so it reads 0 while reset is held and 1 as soon as it is released.
  assign s_cmd_ready    = (state_q == S_IDLE) && !RST;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign wr_count       = wr_count_q;
  assign TCAM_WE        = we_q;
  assign TCAM_ADDR_WR   = addr_q;
  assign TCAM_DIN       = din_q;
  assign TCAM_DATA_MASK = mask_q;

  // NOTE: single-cycle pulses (WE, done, error) default low each cycle and are raised only on the
  // transition that owns them; every assignment here is non-blocking so all state updates together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      mask_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      wr_count_q <= '0;
      busy_cnt_q <= '0;
`ifdef TCAM_UPDATE_CLEAR_EN
      clear_q    <= 1'b0;
`endif
    end else begin
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      case (state_q)
        S_IDLE: begin
          if (s_cmd_valid) begin
            if (op_legal) begin
              state_q    <= S_WAIT_FREE;
              busy_cnt_q <= '0;
              din_q      <= (s_cmd_op == OP_WRITE) ? s_cmd_key : C_INVALID_KEY;
              mask_q     <= (s_cmd_op == OP_WRITE) ? s_cmd_mask : '0;
`ifdef TCAM_UPDATE_CLEAR_EN
              addr_q     <= (s_cmd_op == OP_CLEAR) ? '0 : s_cmd_addr;
              clear_q    <= (s_cmd_op == OP_CLEAR);
`else
              addr_q     <= s_cmd_addr;
`endif
            end else begin
              error_q    <= 1'b1;
              err_code_q <= ERR_BAD_OP;
            end
          end
        end
        S_WAIT_FREE: begin
          if (!TCAM_BUSY) begin
            state_q <= S_ISSUE;
            we_q    <= 1'b1;
          end else if (timeout_hit) begin
            state_q    <= S_IDLE;
            error_q    <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else begin
            busy_cnt_q <= busy_cnt_d[7:0];
          end
        end
        S_ISSUE: begin
          state_q    <= S_WAIT_ACK;
          busy_cnt_q <= '0;
          wr_count_q <= wr_count_q + 32'd1;
        end
        S_WAIT_ACK: begin
          if (!TCAM_BUSY) begin
`ifdef TCAM_UPDATE_CLEAR_EN
            if (clear_q && (addr_q != '1)) begin
              state_q    <= S_WAIT_FREE;
              busy_cnt_q <= '0;
              addr_q     <= addr_q + 1'b1;
            end else begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
`else
            state_q <= S_IDLE;
            done_q  <= 1'b1;
`endif
          end else if (timeout_hit) begin
            state_q    <= S_IDLE;
            error_q    <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else begin
            busy_cnt_q <= busy_cnt_d[7:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_update_ctrl.sv
// Self-checking bench for tcam_update_ctrl: directed and randomized commands against a cycle-timeline
// model of the write port, with BUSY recorded per cycle so the model can replay it.
module tb_tcam_update_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 255;
  localparam int MAXC  = 100000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic [1:0]    s_cmd_op = 2'b00;
  logic [AW-1:0] s_cmd_addr = '0;
  logic [DW-1:0] s_cmd_key = '0;
  logic [DW-1:0] s_cmd_mask = '0;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [31:0]   wr_count;
  logic          TCAM_WE;
  logic [AW-1:0] TCAM_ADDR_WR;
  logic [DW-1:0] TCAM_DIN;
  logic [DW-1:0] TCAM_DATA_MASK;
  logic          TCAM_BUSY = 1'b0;

  tcam_update_ctrl dut (
    .CLK(CLK), .RST(RST),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_op(s_cmd_op),
    .s_cmd_addr(s_cmd_addr), .s_cmd_key(s_cmd_key), .s_cmd_mask(s_cmd_mask),
    .done(done), .error(error), .err_code(err_code), .wr_count(wr_count),
    .TCAM_WE(TCAM_WE), .TCAM_ADDR_WR(TCAM_ADDR_WR), .TCAM_DIN(TCAM_DIN),
    .TCAM_DATA_MASK(TCAM_DATA_MASK), .TCAM_BUSY(TCAM_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] mask;
  } wr_t;

  wr_t         obs_wr[$];
  wr_t         exp_wr[$];
  int          obs_done[$];
  int          obs_err[$];
  logic [1:0]  obs_code[$];
  bit          busy_hist [0:MAXC-1];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_mode = 0;
  int          w0, w1, w2, w3;
  logic [31:0] wr_model = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock, record what the DUT shows in the new cycle, then choose BUSY for that cycle.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_limit: got %0d cycles, expected fewer than %0d", cyc, MAXC);
      $fatal(1);
    end
    if (TCAM_WE) begin
      obs_wr.push_back(wr_t'{cyc, TCAM_ADDR_WR, TCAM_DIN, TCAM_DATA_MASK});
      check("we_after_busy", busy_hist[cyc-1], 0);
      check("we_with_done_err", done | error, 0);
      check("ready_during_op", s_cmd_ready, 0);
    end
    if (done) obs_done.push_back(cyc);
    if (error) begin
      obs_err.push_back(cyc);
      obs_code.push_back(err_code);
    end
    if (done || error) check("done_err_excl", done & error, 0);
    case (busy_mode)
      0:       TCAM_BUSY = 1'b0;
      1:       TCAM_BUSY = ($urandom_range(3) == 0);
      2:       TCAM_BUSY = 1'b1;
      default: TCAM_BUSY = ((cyc >= w0) && (cyc < w1)) || ((cyc >= w2) && (cyc < w3));
    endcase
    busy_hist[cyc] = TCAM_BUSY;
  endtask

  // Timeline model: accept in cycle t, first wait cycle t+1; a free wait cycle c puts WE in c+1,
  // the ack wait starts at c+2, and a free ack cycle c finishes (or moves on) in c+1.
  task automatic model(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] key,
                       input logic [DW-1:0] mask, input int t,
                       output int end_cyc, output bit is_err, output logic [1:0] code);
    bit legal;
    int first, last, c, n;
    exp_wr.delete();
    legal = (op == 2'b00) || (op == 2'b01);
`ifdef TCAM_UPDATE_CLEAR_EN
    legal = legal || (op == 2'b10);
`endif
    if (!legal) begin
      end_cyc = t + 1; is_err = 1'b1; code = 2'b01;
      return;
    end
    first = (op == 2'b10) ? 0 : int'(addr);
    last  = (op == 2'b10) ? DEPTH - 1 : int'(addr);
    c = t + 1;
    for (int a = first; a <= last; a++) begin
      n = 0;
      while (busy_hist[c]) begin
        n++;
        if (n == TMO) begin end_cyc = c + 1; is_err = 1'b1; code = 2'b10; return; end
        c++;
      end
      exp_wr.push_back(wr_t'{c + 1, AW'(a), (op == 2'b00) ? key : {DW{1'b1}},
                             (op == 2'b00) ? mask : {DW{1'b0}}});
      c = c + 2;
      n = 0;
      while (busy_hist[c]) begin
        n++;
        if (n == TMO) begin end_cyc = c + 1; is_err = 1'b1; code = 2'b10; return; end
        c++;
      end
      c = c + 1;
    end
    end_cyc = c; is_err = 1'b0; code = 2'b00;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] key,
                         input logic [DW-1:0] mask, output int t);
    int         t_end, budget, obs_end;
    bit         is_err;
    logic [1:0] code;
    obs_wr.delete(); obs_done.delete(); obs_err.delete(); obs_code.delete();
    check("ready_idle", s_cmd_ready, 1);
    s_cmd_valid = 1'b1; s_cmd_op = op; s_cmd_addr = addr; s_cmd_key = key; s_cmd_mask = mask;
    t = cyc;
    step();
    s_cmd_valid = 1'b0; s_cmd_op = 2'($urandom); s_cmd_addr = AW'($urandom);
    s_cmd_key = $urandom; s_cmd_mask = $urandom;
    budget = 0;
    while (obs_done.size() == 0 && obs_err.size() == 0 && budget < 20000) begin
      step();
      budget++;
    end
    if (budget >= 20000) begin
      check("cmd_hang", 1, 0);
      return;
    end
    check("ready_back", s_cmd_ready, 1);
    repeat (2) step();
    model(op, addr, key, mask, t, t_end, is_err, code);
    wr_model = wr_model + 32'(exp_wr.size());
    obs_end = (obs_done.size() > 0) ? obs_done[0] : ((obs_err.size() > 0) ? obs_err[0] : -1);
    check("n_we", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      check("we_cyc", obs_wr[i].cyc, exp_wr[i].cyc);
      check("we_addr", obs_wr[i].addr, exp_wr[i].addr);
      check("we_din", obs_wr[i].din, exp_wr[i].din);
      check("we_mask", obs_wr[i].mask, exp_wr[i].mask);
    end
    check("n_done", obs_done.size(), is_err ? 0 : 1);
    check("n_error", obs_err.size(), is_err ? 1 : 0);
    check("end_cyc", obs_end, t_end);
    check("err_code", (obs_code.size() > 0) ? obs_code[0] : 2'b00, code);
    check("wr_count", wr_count, wr_model);
    if (exp_wr.size() > 0) begin
      check("addr_hold", TCAM_ADDR_WR, exp_wr[exp_wr.size()-1].addr);
      check("din_hold", TCAM_DIN, exp_wr[exp_wr.size()-1].din);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_we"}, TCAM_WE, 0);
    check({pfx, "_ready"}, s_cmd_ready, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_err_code"}, err_code, 0);
    check({pfx, "_wr_count"}, wr_count, 0);
    check({pfx, "_addr"}, TCAM_ADDR_WR, 0);
    check({pfx, "_din"}, TCAM_DIN, 0);
    check({pfx, "_mask"}, TCAM_DATA_MASK, 0);
  endtask

  initial begin
    #(MAXC * 20);
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int         t, n0, sel;
    logic [1:0] op;

    repeat (3) step();
    check_reset_outputs("reset");
    RST = 1'b0;
    step();
    check("reset_ready_after", s_cmd_ready, 1);

    // Plain write with BUSY low.
    busy_mode = 0;
    run_cmd(2'b00, 5'd3, 32'hDEADBEEF, 32'h000000FF, t);
    check("t1_we_cyc", (obs_wr.size() > 0) ? obs_wr[0].cyc : -1, t + 2);
    check("t1_we_din", (obs_wr.size() > 0) ? obs_wr[0].din : '0, 32'hDEADBEEF);
    check("t1_done_cyc", (obs_done.size() > 0) ? obs_done[0] : -1, t + 4);
    check("t1_wr_count", wr_count, 1);

    // BUSY high for 5 cycles before the strobe and 4 after it.
    busy_mode = 3;
    w0 = cyc + 1; w1 = cyc + 6; w2 = cyc + 8; w3 = cyc + 12;
    run_cmd(2'b00, 5'd17, 32'h12345678, 32'h0F0F0000, t);
    check("t2_we_cyc", (obs_wr.size() > 0) ? obs_wr[0].cyc : -1, t + 7);
    check("t2_done_cyc", (obs_done.size() > 0) ? obs_done[0] : -1, t + 13);

    // BUSY stuck high: timeout, no strobe.
    busy_mode = 2;
    run_cmd(2'b01, 5'd9, 32'h0, 32'h0, t);
    check("t3_err_cyc", (obs_err.size() > 0) ? obs_err[0] : -1, t + 256);
    check("t3_no_we", obs_wr.size(), 0);
    busy_mode = 0;
    step();

    // Reserved op.
    run_cmd(2'b11, 5'd4, 32'hA5A5A5A5, 32'h0, t);
    check("t4_err_cyc", (obs_err.size() > 0) ? obs_err[0] : -1, t + 1);
    check("t4_err_code", (obs_code.size() > 0) ? obs_code[0] : 2'b00, 2'b01);

    // Op 10: full sweep when built in, otherwise rejected like a reserved op.
    n0 = int'(wr_count);
    run_cmd(2'b10, 5'd21, 32'h0, 32'h0, t);
`ifdef TCAM_UPDATE_CLEAR_EN
    check("t5_n_we", obs_wr.size(), DEPTH);
    check("t5_last_we_cyc", (obs_wr.size() > 0) ? obs_wr[obs_wr.size()-1].cyc : -1, t + 95);
    check("t5_done_cyc", (obs_done.size() > 0) ? obs_done[0] : -1, t + 97);
    check("t5_wr_count", wr_count, n0 + DEPTH);
`else
    check("t5_err_cyc", (obs_err.size() > 0) ? obs_err[0] : -1, t + 1);
    check("t5_err_code", (obs_code.size() > 0) ? obs_code[0] : 2'b00, 2'b01);
    check("t5_wr_count", wr_count, n0);
`endif

    // Randomized commands with quiet or randomly toggling BUSY.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(9);
      op = (sel < 5) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      busy_mode = $urandom_range(1);
      run_cmd(op, AW'($urandom), $urandom, $urandom, t);
      repeat ($urandom_range(2)) step();
    end
    busy_mode = 0;
    step();

    // Reset in the middle of an operation.
    obs_wr.delete();
`ifdef TCAM_UPDATE_CLEAR_EN
    s_cmd_valid = 1'b1; s_cmd_op = 2'b10; s_cmd_addr = AW'($urandom);
    step();
    s_cmd_valid = 1'b0;
    n0 = 0;
    while (!(TCAM_WE && (TCAM_ADDR_WR == AW'(10))) && n0 < 200) begin
      step();
      n0++;
    end
    check("rst_reached_addr10", n0 < 200, 1);
`else
    busy_mode = 2;
    s_cmd_valid = 1'b1; s_cmd_op = 2'b00; s_cmd_addr = AW'($urandom); s_cmd_key = $urandom;
    step();
    s_cmd_valid = 1'b0;
    repeat (20) step();
`endif
    RST = 1'b1;
    step();
    check_reset_outputs("midop_rst");
    RST = 1'b0;
    busy_mode = 0;
    wr_model = '0;
    n0 = obs_wr.size();
    step();
    check("midop_ready", s_cmd_ready, 1);
    repeat (3) step();
    check("midop_no_we", obs_wr.size(), n0);
    run_cmd(2'b00, 5'd7, 32'hCAFEF00D, 32'h00FF00FF, t);
    check("midop_new_wr_count", wr_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
